// File: rtl/dcache_data_ctrl.sv
// Request/response sequencer for the single-port dcache data SRAM macro: one timed access per request.
// Optional perf counters (perf_rd_cnt/perf_wr_cnt) are built when DCACHE_DATA_CTRL_PERF_EN is defined.
module dcache_data_ctrl #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_WMASKS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_we,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
`ifdef DCACHE_DATA_CTRL_PERF_EN
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
`endif
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  if (NUM_WMASKS != DATA_WIDTH / 8) begin : g_wmask_check
    $error("dcache_data_ctrl: NUM_WMASKS must equal DATA_WIDTH/8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;

  // sram_web stays low through ISSUE for writes, so it doubles as the access-type flag there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            sram_csb   <= 1'b0;
            sram_web   <= ~req_we;
            sram_addr  <= req_addr;
            sram_din   <= req_wdata;
            sram_wmask <= req_we ? req_wmask : '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          if (sram_web) begin
            state <= WAIT;
          end else begin
            resp_valid <= 1'b1;
            resp_we    <= 1'b1;
            state      <= RESP;
          end
        end
        WAIT: begin
          resp_rdata <= sram_dout;
          resp_we    <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_DATA_CTRL_PERF_EN
  // One count per issued access, attributed by type during its ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else if (state == ISSUE) begin
      if (sram_web) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      else          perf_wr_cnt <= perf_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Bench for dcache_data_ctrl: behavioural SRAM macro plus a line-array reference model.
module tb_dcache_data_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [3:0]   req_addr;
  logic [31:0]  req_wmask;
  logic [255:0] req_wdata;
  logic         resp_valid, resp_ready, resp_we;
  logic [255:0] resp_rdata;
  logic         sram_csb, sram_web;
  logic [31:0]  sram_wmask;
  logic [3:0]   sram_addr;
  logic [255:0] sram_din, sram_dout;
`ifdef DCACHE_DATA_CTRL_PERF_EN
  logic [31:0]  perf_rd_cnt, perf_wr_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_data_ctrl #(.DATA_WIDTH(256), .ADDR_WIDTH(4), .NUM_WMASKS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rdata(resp_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din),
`ifdef DCACHE_DATA_CTRL_PERF_EN
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
`endif
    .sram_dout(sram_dout)
  );

  // Macro model: pins sampled at posedge, array/dout updated in the second half of the cycle.
  logic [255:0] sram_mem [16];
  logic         m_csb = 1'b1, m_web = 1'b1;
  logic [3:0]   m_addr;
  logic [31:0]  m_wmask;
  logic [255:0] m_din;
  always @(posedge clk) begin
    m_csb <= sram_csb; m_web <= sram_web; m_addr <= sram_addr;
    m_wmask <= sram_wmask; m_din <= sram_din;
  end
  always @(negedge clk) begin
    if (m_csb === 1'b0) begin
      if (m_web === 1'b0) begin
        for (int b = 0; b < 32; b++)
          if (m_wmask[b]) sram_mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[m_addr];
      end
    end
  end

  // Chip-select observation: total low cycles and a sticky flag for back-to-back lows.
  int csb_low_cnt = 0;
  bit csb_adj = 1'b0;
  bit prev_low = 1'b0;
  always @(negedge clk) begin
    if (sram_csb === 1'b0) begin
      csb_low_cnt++;
      if (prev_low) csb_adj = 1'b1;
    end
    prev_low = (sram_csb === 1'b0);
  end

  logic [255:0] ref_mem [16];

  task automatic model_write(input logic [3:0] a, input logic [31:0] m, input logic [255:0] d);
    for (int b = 0; b < 32; b++)
      if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  // Called at a negedge; returns at the negedge of the first resp_valid cycle.
  // lat = cycles from the accept cycle to that cycle, or -1 on timeout.
  task automatic send_req(input logic we, input logic [3:0] addr, input logic [31:0] wm,
                          input logic [255:0] wd, output int lat);
    int n, acc;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wmask = wm; req_wdata = wd;
    resp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    lat = (resp_valid === 1'b1) ? cyc - acc : -1;
    if (we) model_write(addr, wm, wd);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready got=%b want=1", req_ready); n_fail++; end n_tests++;
    if (resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid got=%b want=0", resp_valid); n_fail++; end n_tests++;
    if (resp_we !== 1'b0) begin $display("FAIL reset_resp_we got=%b want=0", resp_we); n_fail++; end n_tests++;
    if (resp_rdata !== 256'd0) begin $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); n_fail++; end n_tests++;
    if (sram_csb !== 1'b1 || sram_web !== 1'b1) begin $display("FAIL reset_csb_web got=%b%b want=11", sram_csb, sram_web); n_fail++; end n_tests++;
    if (sram_wmask !== 32'd0 || sram_addr !== 4'd0 || sram_din !== 256'd0) begin
      $display("FAIL reset_sram_pins wmask=%h addr=%h din=%h want all 0", sram_wmask, sram_addr, sram_din); n_fail++;
    end n_tests++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    send_req(1'b1, 4'd3, 32'hFFFF_FFFF, {32{8'hA5}}, lat);
    if (lat !== 2) begin $display("FAIL wr_latency got=%0d want=2", lat); n_fail++; end n_tests++;
    if (resp_we !== 1'b1) begin $display("FAIL wr_resp_we got=%b want=1", resp_we); n_fail++; end n_tests++;
    if (resp_rdata !== 256'd0) begin $display("FAIL wr_ack_rdata_hold got=%h want=0", resp_rdata); n_fail++; end n_tests++;
    take_resp();
    send_req(1'b0, 4'd3, 32'd0, 256'd0, lat);
    if (lat !== 3) begin $display("FAIL rd_latency got=%0d want=3", lat); n_fail++; end n_tests++;
    if (resp_we !== 1'b0) begin $display("FAIL rd_resp_we got=%b want=0", resp_we); n_fail++; end n_tests++;
    if (resp_rdata !== {32{8'hA5}}) begin $display("FAIL rd_data got=%h want=a5..a5", resp_rdata); n_fail++; end n_tests++;
    take_resp();
  endtask

  task automatic test_partial_mask();
    int lat;
    send_req(1'b1, 4'd7, 32'hFFFF_FFFF, 256'd0, lat); take_resp();
    send_req(1'b1, 4'd7, 32'h0000_0001, {256{1'b1}}, lat); take_resp();
    send_req(1'b0, 4'd7, 32'd0, 256'd0, lat);
    if (resp_rdata !== 256'hFF) begin $display("FAIL partial_mask got=%h want=ff", resp_rdata); n_fail++; end n_tests++;
    take_resp();
  endtask

  task automatic test_wmask_zero();
    int lat;
    logic [255:0] d0;
    d0 = rand_line();
    send_req(1'b1, 4'd5, 32'hFFFF_FFFF, d0, lat); take_resp();
    send_req(1'b1, 4'd5, 32'd0, ~d0, lat);
    if (lat !== 2 || resp_we !== 1'b1) begin $display("FAIL wmask0_ack lat=%0d we=%b want 2/1", lat, resp_we); n_fail++; end n_tests++;
    take_resp();
    send_req(1'b0, 4'd5, 32'd0, 256'd0, lat);
    if (resp_rdata !== d0) begin $display("FAIL wmask0_unchanged got=%h want=%h", resp_rdata, d0); n_fail++; end n_tests++;
    take_resp();
  endtask

  task automatic test_backpressure();
    int lat, low0;
    logic [255:0] held;
    send_req(1'b0, 4'd3, 32'd0, 256'd0, lat);
    held = resp_rdata;
    if (held !== {32{8'hA5}}) begin $display("FAIL bp_data got=%h want=a5..a5", held); n_fail++; end n_tests++;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wmask = '1; req_wdata = 256'd0;
    low0 = csb_low_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || sram_csb !== 1'b1) begin
        $display("FAIL bp_hold_%0d valid=%b ready=%b csb=%b rdata=%h want 1/0/1/%h", i, resp_valid, req_ready, sram_csb, resp_rdata, held);
        n_fail++;
      end
      n_tests++;
    end
    if (csb_low_cnt !== low0) begin $display("FAIL bp_no_access got=%0d want=%0d", csb_low_cnt, low0); n_fail++; end n_tests++;
    req_valid = 1'b0;
    take_resp();
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int low0, n;
    logic [255:0] d;
    low0 = csb_low_cnt;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = rand_line();
      req_valid = 1'b1; req_we = i[0]; req_addr = 4'(i + 8); req_wmask = '1; req_wdata = d;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      acc[i] = cyc;
      if (i[0]) model_write(4'(i + 8), 32'hFFFF_FFFF, d);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    resp_ready = 1'b0;
    if (acc[1] - acc[0] !== 4) begin $display("FAIL b2b_gap_rd got=%0d want=4", acc[1] - acc[0]); n_fail++; end n_tests++;
    if (acc[2] - acc[1] !== 3) begin $display("FAIL b2b_gap_wr got=%0d want=3", acc[2] - acc[1]); n_fail++; end n_tests++;
    if (acc[3] - acc[2] !== 4) begin $display("FAIL b2b_gap_rd2 got=%0d want=4", acc[3] - acc[2]); n_fail++; end n_tests++;
    if (csb_low_cnt - low0 !== 4) begin $display("FAIL b2b_csb_count got=%0d want=4", csb_low_cnt - low0); n_fail++; end n_tests++;
    if (csb_adj !== 1'b0) begin $display("FAIL b2b_csb_adjacent got=%b want=0", csb_adj); n_fail++; end n_tests++;
  endtask

  task automatic test_random();
    int lat, hold;
    logic we;
    logic [3:0] a;
    logic [31:0] m;
    logic [255:0] d, exp_rd, last_rd;
    bit have_rd;
    have_rd = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) begin
      send_req(1'b1, 4'(i), 32'hFFFF_FFFF, rand_line(), lat);
      take_resp();
    end
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: m = 32'd0;
        1: m = 32'hFFFF_FFFF;
        default: m = $urandom();
      endcase
      d = rand_line();
      exp_rd = ref_mem[a];
      send_req(we, a, m, d, lat);
      if (lat !== (we ? 2 : 3)) begin $display("FAIL rnd_latency_%0d got=%0d want=%0d", t, lat, we ? 2 : 3); n_fail++; end n_tests++;
      if (resp_we !== we) begin $display("FAIL rnd_resp_we_%0d got=%b want=%b", t, resp_we, we); n_fail++; end n_tests++;
      if (!we) begin
        if (resp_rdata !== exp_rd) begin $display("FAIL rnd_rdata_%0d got=%h want=%h", t, resp_rdata, exp_rd); n_fail++; end n_tests++;
        last_rd = exp_rd; have_rd = 1'b1;
      end else if (have_rd) begin
        if (resp_rdata !== last_rd) begin $display("FAIL rnd_ack_hold_%0d got=%h want=%h", t, resp_rdata, last_rd); n_fail++; end n_tests++;
      end
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      if (resp_valid !== 1'b1 || resp_we !== we) begin $display("FAIL rnd_stall_%0d valid=%b we=%b want 1/%b", t, resp_valid, resp_we, we); n_fail++; end n_tests++;
      take_resp();
    end
    if (csb_adj !== 1'b0) begin $display("FAIL rnd_csb_adjacent got=%b want=0", csb_adj); n_fail++; end n_tests++;
  endtask

  task automatic test_reset_mid();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; resp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (resp_valid !== 1'b0) begin $display("FAIL midrst_resp_valid got=%b want=0", resp_valid); n_fail++; end n_tests++;
    if (req_ready !== 1'b1) begin $display("FAIL midrst_req_ready got=%b want=1", req_ready); n_fail++; end n_tests++;
    if (sram_csb !== 1'b1) begin $display("FAIL midrst_csb got=%b want=1", sram_csb); n_fail++; end n_tests++;
    repeat (2) @(negedge clk);
    if (resp_valid !== 1'b0) begin $display("FAIL midrst_dropped got=%b want=0", resp_valid); n_fail++; end n_tests++;
  endtask

`ifdef DCACHE_DATA_CTRL_PERF_EN
  task automatic test_perf();
    int lat;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin send_req(1'b1, 4'(i), 32'hF, rand_line(), lat); take_resp(); end
    for (int i = 0; i < 3; i++) begin send_req(1'b0, 4'(i), 32'd0, 256'd0, lat); take_resp(); end
    if (perf_wr_cnt !== 32'd2) begin $display("FAIL perf_wr got=%0d want=2", perf_wr_cnt); n_fail++; end n_tests++;
    if (perf_rd_cnt !== 32'd3) begin $display("FAIL perf_rd got=%0d want=3", perf_rd_cnt); n_fail++; end n_tests++;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    if (perf_wr_cnt !== 32'd0 || perf_rd_cnt !== 32'd0) begin
      $display("FAIL perf_clear wr=%0d rd=%0d want 0/0", perf_wr_cnt, perf_rd_cnt); n_fail++;
    end n_tests++;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_partial_mask();
    test_wmask_zero();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef DCACHE_DATA_CTRL_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
